emac_tx_change: RTL and testbench

Transmit-side adapter between the user-side FIFO interface (ff_tx_*) and the MAC transmit user interface (Tx_mac_*), in the Clk_user domain. It is the counterpart of the receive adapter.
- Buffers upstream words in a small FIFO so the two sides are decoupled.
- Enforces sop/eop framing before anything reaches the MAC.
- Counts framing violations and upstream-flagged errors.

---
 rtl/emac_tx_change.sv | 124 ++++++++++++
 tb/tb_emac_tx_change.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/emac_tx_change.sv
// Transmit adapter from the user-side ff_tx_* word stream to the MAC Tx_mac_* interface.
// Words pass through a hold register for framing repair, then a small FIFO, then a registered output stage.
module emac_tx_change #(
  parameter int DEPTH = 8
) (
  input  logic        Clk_user,
  input  logic        Reset_n,
  input  logic [31:0] ff_tx_data,
  input  logic [1:0]  ff_tx_mod,
  input  logic        ff_tx_sop,
  input  logic        ff_tx_eop,
  input  logic        ff_tx_wren,
  input  logic        ff_tx_err,
  output logic        ff_tx_rdy,
  input  logic        Tx_mac_wa,
  output logic        Tx_mac_wr,
  output logic [31:0] Tx_mac_data,
  output logic [1:0]  Tx_mac_BE,
  output logic        Tx_mac_sop,
  output logic        Tx_mac_eop,
  output logic [7:0]  cnt_stray,
  output logic [7:0]  cnt_trunc,
  output logic [7:0]  cnt_uerr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] RdyMaxOcc = (AW+1)'(DEPTH - 2);

  typedef enum logic {IDLE, IN_FRAME} state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  mod;
    logic        sop;
    logic        eop;
  } word_t;

  state_e      state_q, state_d;
  word_t       hold_q, hold_d, in_word, wr_word, tx_word_q;
  logic        hold_vld_q, hold_vld_d;
  logic        rdy_q, rdy_d, tx_wr_q;
  logic [7:0]  stray_q, stray_d, trunc_q, trunc_d, uerr_q, uerr_d;
  logic [AW:0] wptr_q, rptr_q, occ, occ_next;
  word_t       mem [DEPTH];

  logic accept, load, truncate, fifo_wr, pop, full, empty;

  function automatic logic [7:0] satInc(input logic [7:0] c, input logic inc);
    return (inc && c != 8'hFF) ? c + 8'd1 : c;
  endfunction

  assign full     = (wptr_q == {~rptr_q[AW], rptr_q[AW-1:0]});
  assign empty    = (wptr_q == rptr_q);
  assign occ      = wptr_q - rptr_q;
  assign pop      = Tx_mac_wa && !empty;
  assign accept   = ff_tx_wren && rdy_q;
  assign in_word  = '{data: ff_tx_data, mod: ff_tx_mod, sop: ff_tx_sop, eop: ff_tx_eop};
  assign load     = accept && (state_q == IN_FRAME || ff_tx_sop);
  assign truncate = accept && (state_q == IN_FRAME) && ff_tx_sop;
  // In IN_FRAME the hold is always a non-eop word; in IDLE it is either empty or a finished eop word.
  assign fifo_wr  = hold_vld_q && (hold_q.eop || (accept && state_q == IN_FRAME)) && !full;

  always_comb begin
    wr_word = hold_q;
    if (truncate) begin
      wr_word.eop = 1'b1;
      wr_word.mod = 2'b00;
    end
    hold_d     = load ? in_word : hold_q;
    hold_vld_d = load ? 1'b1 : (fifo_wr ? 1'b0 : hold_vld_q);
    state_d    = load ? (ff_tx_eop ? IDLE : IN_FRAME) : state_q;
    occ_next   = occ + (AW+1)'(fifo_wr) - (AW+1)'(pop);
    rdy_d      = (occ_next <= RdyMaxOcc);
    stray_d    = satInc(stray_q, accept && state_q == IDLE && !ff_tx_sop);
    trunc_d    = satInc(trunc_q, truncate);
    uerr_d     = satInc(uerr_q, accept && ff_tx_eop && ff_tx_err);
  end

  always_ff @(posedge Clk_user or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
      stray_q    <= '0;
      trunc_q    <= '0;
      uerr_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      tx_wr_q    <= 1'b0;
      tx_word_q  <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      rdy_q      <= rdy_d;
      stray_q    <= stray_d;
      trunc_q    <= trunc_d;
      uerr_q     <= uerr_d;
      if (fifo_wr) wptr_q <= wptr_q + 1'b1;
      if (pop) begin
        rptr_q    <= rptr_q + 1'b1;
        tx_word_q <= mem[rptr_q[AW-1:0]];
      end
      tx_wr_q <= pop;
    end
  end

  // Storage array carries no reset; only the pointers define its contents.
  always_ff @(posedge Clk_user) begin
    if (fifo_wr) mem[wptr_q[AW-1:0]] <= wr_word;
  end

  assign ff_tx_rdy   = rdy_q;
  assign Tx_mac_wr   = tx_wr_q;
  assign Tx_mac_data = tx_word_q.data;
  assign Tx_mac_BE   = tx_word_q.mod;
  assign Tx_mac_sop  = tx_word_q.sop;
  assign Tx_mac_eop  = tx_word_q.eop;
  assign cnt_stray   = stray_q;
  assign cnt_trunc   = trunc_q;
  assign cnt_uerr    = uerr_q;

endmodule

// File: tb/tb_emac_tx_change.sv
// Directed bench for emac_tx_change: expected MAC words are queued as stimulus is driven
// and compared when the DUT raises Tx_mac_wr.
module tb_emac_tx_change;

  logic        Clk_user = 1'b0;
  logic        Reset_n = 1'b0;
  logic [31:0] ff_tx_data = '0;
  logic [1:0]  ff_tx_mod = '0;
  logic        ff_tx_sop = 1'b0, ff_tx_eop = 1'b0, ff_tx_wren = 1'b0, ff_tx_err = 1'b0;
  logic        ff_tx_rdy;
  logic        Tx_mac_wa = 1'b1;
  logic        Tx_mac_wr;
  logic [31:0] Tx_mac_data;
  logic [1:0]  Tx_mac_BE;
  logic        Tx_mac_sop, Tx_mac_eop;
  logic [7:0]  cnt_stray, cnt_trunc, cnt_uerr;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          accCyc = 0;
  logic [35:0] expQ[$];
  int          rxCyc[$];
  logic [35:0] monExp;

  emac_tx_change #(.DEPTH(8)) dut (
    .Clk_user(Clk_user), .Reset_n(Reset_n),
    .ff_tx_data(ff_tx_data), .ff_tx_mod(ff_tx_mod), .ff_tx_sop(ff_tx_sop),
    .ff_tx_eop(ff_tx_eop), .ff_tx_wren(ff_tx_wren), .ff_tx_err(ff_tx_err),
    .ff_tx_rdy(ff_tx_rdy), .Tx_mac_wa(Tx_mac_wa), .Tx_mac_wr(Tx_mac_wr),
    .Tx_mac_data(Tx_mac_data), .Tx_mac_BE(Tx_mac_BE), .Tx_mac_sop(Tx_mac_sop),
    .Tx_mac_eop(Tx_mac_eop), .cnt_stray(cnt_stray), .cnt_trunc(cnt_trunc),
    .cnt_uerr(cnt_uerr)
  );

  always #5 Clk_user = ~Clk_user;
  always @(posedge Clk_user) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every MAC word must match the oldest queued expectation.
  always @(negedge Clk_user) begin
    if (Reset_n && Tx_mac_wr === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_wr", 36'(Tx_mac_wr), 36'd0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("mac_word", {Tx_mac_data, Tx_mac_BE, Tx_mac_sop, Tx_mac_eop}, monExp);
        rxCyc.push_back(cyc);
      end
    end
  end

  task automatic pushExp(input logic [31:0] d, input logic [1:0] be, input logic s, input logic e);
    expQ.push_back({d, be, s, e});
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic [1:0] m, input logic s,
                               input logic e, input logic er, input int maxWait, output bit ok);
    int waited;
    waited = 0;
    ok = 1'b0;
    ff_tx_data = d; ff_tx_mod = m; ff_tx_sop = s; ff_tx_eop = e; ff_tx_err = er;
    ff_tx_wren = 1'b1;
    while (!ok && waited < maxWait) begin
      if (ff_tx_rdy === 1'b1) ok = 1'b1;
      @(posedge Clk_user); #1;
      waited++;
    end
    accCyc = cyc;
    ff_tx_wren = 1'b0; ff_tx_sop = 1'b0; ff_tx_eop = 1'b0; ff_tx_err = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] d, input logic [1:0] m, input logic s,
                          input logic e, input logic er);
    bit ok;
    applyStimulus(d, m, s, e, er, 50, ok);
    checkOutput("accept", 36'(ok), 36'd1);
  endtask

  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 400) begin
      @(posedge Clk_user); #1;
      n++;
    end
    repeat (3) @(posedge Clk_user);
    #1;
    checkOutput(tag, 36'(expQ.size()), 36'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    int nAcc;
    int t3;

    $display("[TB] reset");
    repeat (3) @(posedge Clk_user);
    #1;
    checkOutput("rst_rdy", 36'(ff_tx_rdy), 36'd0);
    checkOutput("rst_wr", 36'(Tx_mac_wr), 36'd0);
    checkOutput("rst_word", {Tx_mac_data, Tx_mac_BE, Tx_mac_sop, Tx_mac_eop}, 36'd0);
    checkOutput("rst_cnts", {12'd0, cnt_stray, cnt_trunc, cnt_uerr}, 36'd0);
    #2 Reset_n = 1'b1;
    #1;
    checkOutput("rdy_before_edge", 36'(ff_tx_rdy), 36'd0);
    @(posedge Clk_user); #1;
    checkOutput("rdy_first_edge", 36'(ff_tx_rdy), 36'd1);

    $display("[TB] four-word frame");
    rxCyc.delete();
    pushExp(32'h1111_1111, 2'd0, 1'b1, 1'b0);
    pushExp(32'h2222_2222, 2'd0, 1'b0, 1'b0);
    pushExp(32'h3333_3333, 2'd0, 1'b0, 1'b0);
    pushExp(32'h4444_4444, 2'd2, 1'b0, 1'b1);
    sendWord(32'h1111_1111, 2'd0, 1'b1, 1'b0, 1'b0);
    sendWord(32'h2222_2222, 2'd0, 1'b0, 1'b0, 1'b0);
    sendWord(32'h3333_3333, 2'd0, 1'b0, 1'b0, 1'b0);
    sendWord(32'h4444_4444, 2'd2, 1'b0, 1'b1, 1'b0);
    t3 = accCyc;
    waitDrain("t1_drain");
    checkOutput("t1_count", 36'(rxCyc.size()), 36'd4);
    checkOutput("t1_last_cycle", 36'(rxCyc[3]), 36'(t3 + 2));
    checkOutput("t1_consecutive", 36'(rxCyc[3] - rxCyc[0]), 36'd3);

    $display("[TB] stray word and single-word latency");
    rxCyc.delete();
    sendWord(32'hDEAD_BEEF, 2'd0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge Clk_user);
    #1;
    checkOutput("stray_cnt", 36'(cnt_stray), 36'd1);
    checkOutput("stray_none_out", 36'(rxCyc.size()), 36'd0);
    pushExp(32'h0000_5151, 2'd1, 1'b1, 1'b1);
    sendWord(32'h0000_5151, 2'd1, 1'b1, 1'b1, 1'b0);
    t3 = accCyc;
    waitDrain("lat_drain");
    checkOutput("lat_cycle", 36'(rxCyc[0]), 36'(t3 + 2));

    $display("[TB] truncated frame");
    pushExp(32'h0000_00A0, 2'd0, 1'b1, 1'b0);
    pushExp(32'h0000_00A1, 2'd0, 1'b0, 1'b1);
    pushExp(32'h0000_00B0, 2'd0, 1'b1, 1'b0);
    pushExp(32'h0000_00B1, 2'd1, 1'b0, 1'b1);
    sendWord(32'h0000_00A0, 2'd0, 1'b1, 1'b0, 1'b0);
    sendWord(32'h0000_00A1, 2'd3, 1'b0, 1'b0, 1'b0);
    sendWord(32'h0000_00B0, 2'd0, 1'b1, 1'b0, 1'b0);
    sendWord(32'h0000_00B1, 2'd1, 1'b0, 1'b1, 1'b0);
    waitDrain("trunc_drain");
    checkOutput("trunc_cnt", 36'(cnt_trunc), 36'd1);

    $display("[TB] backpressure with Tx_mac_wa low");
    Tx_mac_wa = 1'b0;
    rxCyc.delete();
    nAcc = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(32'h5000_0000 + 32'(i), 2'(i), 1'b1, 1'b1, 1'b0, 4, ok);
      if (!ok) break;
      pushExp(32'h5000_0000 + 32'(i), 2'(i), 1'b1, 1'b1);
      nAcc++;
    end
    checkOutput("bp_accepted", 36'(nAcc), 36'd8);
    checkOutput("bp_rdy_low", 36'(ff_tx_rdy), 36'd0);
    checkOutput("bp_no_output", 36'(rxCyc.size()), 36'd0);
    Tx_mac_wa = 1'b1;
    for (int i = nAcc; i < 20; i++) begin
      pushExp(32'h5000_0000 + 32'(i), 2'(i), 1'b1, 1'b1);
      sendWord(32'h5000_0000 + 32'(i), 2'(i), 1'b1, 1'b1, 1'b0);
    end
    waitDrain("bp_drain");
    checkOutput("bp_count", 36'(rxCyc.size()), 36'd20);

    $display("[TB] user error saturation");
    rxCyc.delete();
    for (int i = 0; i < 300; i++) begin
      pushExp(32'h7700_0000 + 32'(i), 2'd3, 1'b1, 1'b1);
      sendWord(32'h7700_0000 + 32'(i), 2'd3, 1'b1, 1'b1, 1'b1);
    end
    waitDrain("uerr_drain");
    checkOutput("uerr_cnt", 36'(cnt_uerr), 36'd255);
    checkOutput("uerr_count", 36'(rxCyc.size()), 36'd300);

    $display("[TB] reset mid-frame");
    rxCyc.delete();
    pushExp(32'h0000_00C0, 2'd0, 1'b1, 1'b0);
    sendWord(32'h0000_00C0, 2'd0, 1'b1, 1'b0, 1'b0);
    sendWord(32'h0000_00C1, 2'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge Clk_user);
    #1;
    checkOutput("mid_partial", 36'(rxCyc.size()), 36'd1);
    #2 Reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_rdy", 36'(ff_tx_rdy), 36'd0);
    checkOutput("mid_rst_wr", 36'(Tx_mac_wr), 36'd0);
    checkOutput("mid_rst_word", {Tx_mac_data, Tx_mac_BE, Tx_mac_sop, Tx_mac_eop}, 36'd0);
    checkOutput("mid_rst_cnts", {12'd0, cnt_stray, cnt_trunc, cnt_uerr}, 36'd0);
    @(posedge Clk_user);
    #3 Reset_n = 1'b1;
    @(posedge Clk_user); #1;
    checkOutput("mid_rdy_back", 36'(ff_tx_rdy), 36'd1);
    rxCyc.delete();
    pushExp(32'h0000_00D0, 2'd0, 1'b1, 1'b0);
    pushExp(32'h0000_00D1, 2'd3, 1'b0, 1'b1);
    sendWord(32'h0000_00D0, 2'd0, 1'b1, 1'b0, 1'b0);
    sendWord(32'h0000_00D1, 2'd3, 1'b0, 1'b1, 1'b0);
    waitDrain("fresh_drain");
    checkOutput("fresh_count", 36'(rxCyc.size()), 36'd2);
    checkOutput("fresh_cnts", {12'd0, cnt_stray, cnt_trunc, cnt_uerr}, 36'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
